// File: rtl/argmax_fix16_if.sv
// Handshake and result bundle between the argmax stage, its controller and the
// class-score mux of the inference engine.
interface argmax_fix16_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned IDX_W = 4;

    logic                         start;
    logic                         dnn_done;
    logic        [IDX_W-1:0]      out_idx;
    logic signed [DATA_WIDTH-1:0] score;
    logic                         busy;
    logic                         valid;
    logic        [IDX_W-1:0]      class_idx;
    logic signed [DATA_WIDTH-1:0] class_val;
    logic        [DATA_WIDTH-1:0] margin;

    modport master (
        output start, dnn_done, score,
        input  out_idx, busy, valid, class_idx, class_val, margin
    );

    modport slave (
        input  start, dnn_done, score,
        output out_idx, busy, valid, class_idx, class_val, margin
    );
endinterface

// File: rtl/argmax_fix16.sv
// Scans the class scores one per cycle once inference is done and reports the
// winning class, its score and the margin to the runner-up.
module argmax_fix16 #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_CLASSES = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    argmax_fix16_if.slave bus
);
    localparam int unsigned IDX_W = 4;
    localparam int unsigned MW    = DATA_WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;

    state_e                       state_q, state_d;
    logic        [IDX_W-1:0]      cnt_q, cnt_d;
    logic        [IDX_W-1:0]      out_idx_q, out_idx_d;
    logic                         busy_q, busy_d;
    logic                         valid_q, valid_d;
    logic signed [DATA_WIDTH-1:0] best_q, best_d;
    logic signed [DATA_WIDTH-1:0] second_q, second_d;
    logic        [IDX_W-1:0]      bidx_q, bidx_d;
    logic        [IDX_W-1:0]      class_idx_q, class_idx_d;
    logic signed [DATA_WIDTH-1:0] class_val_q, class_val_d;
    logic        [DATA_WIDTH-1:0] margin_q, margin_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            best_q      <= '0;
            second_q    <= '0;
            bidx_q      <= '0;
            class_idx_q <= '0;
            class_val_q <= '0;
            margin_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            best_q      <= best_d;
            second_q    <= second_d;
            bidx_q      <= bidx_d;
            class_idx_q <= class_idx_d;
            class_val_q <= class_val_d;
            margin_q    <= margin_d;
        end
    end

    // Losing dnn_done mid-scan means the scores are no longer trustworthy: abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start && bus.dnn_done) state_d = S_SCAN;
            S_SCAN: begin
                if (!bus.dnn_done)           state_d = S_IDLE;
                else if (cnt_q == LAST_IDX)  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = '0;
        out_idx_d   = '0;
        busy_d      = 1'b0;
        valid_d     = 1'b0;
        best_d      = best_q;
        second_d    = second_q;
        bidx_d      = bidx_q;
        class_idx_d = class_idx_q;
        class_val_d = class_val_q;
        margin_d    = margin_q;

        // Strict compares keep the lowest index on ties; an equal score lands in second.
        if (state_q == S_SCAN && bus.dnn_done) begin
            if (cnt_q == '0) begin
                best_d   = bus.score;
                second_d = SCORE_MIN;
                bidx_d   = '0;
            end else if (bus.score > best_q) begin
                second_d = best_q;
                best_d   = bus.score;
                bidx_d   = cnt_q;
            end else if (bus.score > second_q) begin
                second_d = bus.score;
            end
        end

        if (state_d == S_SCAN) begin
            busy_d = 1'b1;
            if (state_q == S_SCAN) begin
                cnt_d     = IDX_W'(cnt_q + 1'b1);
                out_idx_d = IDX_W'(cnt_q + 1'b1);
            end
        end

        // best >= second always, so the widened difference fits DATA_WIDTH unsigned.
        if (state_d == S_DONE) begin
            valid_d     = 1'b1;
            class_idx_d = bidx_d;
            class_val_d = best_d;
            margin_d    = DATA_WIDTH'(MW'(best_d) - MW'(second_d));
        end
    end

    assign bus.out_idx   = out_idx_q;
    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.class_idx = class_idx_q;
    assign bus.class_val = class_val_q;
    assign bus.margin    = margin_q;
endmodule

// File: tb/tb_argmax_fix16.sv
// Directed and randomized checks of argmax_fix16 against an array-based reference model.
module tb_argmax_fix16;
    localparam int unsigned DW = 16;
    localparam int unsigned NC = 10;

    logic clk = 1'b0;
    logic rst_n;

    argmax_fix16_if #(.DATA_WIDTH(DW)) bus();

    argmax_fix16 #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] sc [16];
    assign bus.score = sc[bus.out_idx];

    int n_tests = 0;
    int n_fail  = 0;

    logic        [3:0]    exp_idx;
    logic signed [DW-1:0] exp_val;
    logic        [DW-1:0] exp_margin;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: highest score with lowest index wins; runner-up is the best of the rest.
    task automatic model(output logic [3:0] idx, output logic signed [DW-1:0] val,
                         output logic [DW-1:0] mg);
        int best, second, bi;
        best = int'(sc[0]);
        bi   = 0;
        for (int i = 1; i < int'(NC); i++)
            if (int'(sc[i]) > best) begin
                best = int'(sc[i]);
                bi   = i;
            end
        second = -(2 ** (DW - 1));
        for (int i = 0; i < int'(NC); i++)
            if (i != bi && int'(sc[i]) > second) second = int'(sc[i]);
        idx = 4'(bi);
        val = DW'(best);
        mg  = DW'(best - second);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_idx"},    32'(bus.class_idx), 32'(exp_idx));
        check({tag, "_val"},    32'(bus.class_val), 32'(exp_val));
        check({tag, "_margin"}, 32'(bus.margin),    32'(exp_margin));
    endtask

    function automatic logic signed [DW-1:0] rnd(input int mode);
        case (mode)
            0:       return DW'($urandom);
            1:       return DW'(int'($urandom_range(0, 3)) - 2);
            default: return ($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000;
        endcase
    endfunction

    // One classification; abort_at/pulse_at select a scan cycle (-1 = none).
    task automatic run(input string tag, input int abort_at, input int pulse_at, input bit hold);
        logic        [3:0]    ni;
        logic signed [DW-1:0] nv;
        logic        [DW-1:0] nm;
        model(ni, nv, nm);
        bus.start    = 1'b1;
        bus.dnn_done = 1'b1;
        tick();
        if (!hold) bus.start = 1'b0;
        for (int k = 0; k < int'(NC); k++) begin
            check({tag, "_out_idx"}, 32'(bus.out_idx), k);
            check({tag, "_busy"},    32'(bus.busy), 1);
            check({tag, "_valid"},   32'(bus.valid), 0);
            if (k == pulse_at)     bus.start = 1'b1;
            if (k == pulse_at + 1) bus.start = hold;
            if (k == abort_at) begin
                bus.dnn_done = 1'b0;
                tick();
                check({tag, "_abort_busy"},    32'(bus.busy), 0);
                check({tag, "_abort_valid"},   32'(bus.valid), 0);
                check({tag, "_abort_out_idx"}, 32'(bus.out_idx), 0);
                check_results({tag, "_abort_held"});
                tick();
                check({tag, "_abort_valid2"}, 32'(bus.valid), 0);
                check({tag, "_abort_busy2"},  32'(bus.busy), 0);
                bus.dnn_done = 1'b1;
                return;
            end
            tick();
        end
        exp_idx    = ni;
        exp_val    = nv;
        exp_margin = nm;
        check({tag, "_done_valid"},   32'(bus.valid), 1);
        check({tag, "_done_busy"},    32'(bus.busy), 0);
        check({tag, "_done_out_idx"}, 32'(bus.out_idx), 0);
        check_results(tag);
        tick();
        check({tag, "_post_valid"}, 32'(bus.valid), 0);
        check({tag, "_post_busy"},  32'(bus.busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) sc[i] = '0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dnn_done = 1'b0;
        exp_idx      = '0;
        exp_val      = '0;
        exp_margin   = '0;
        #1;
        check("rst_busy",    32'(bus.busy), 0);
        check("rst_valid",   32'(bus.valid), 0);
        check("rst_out_idx", 32'(bus.out_idx), 0);
        check_results("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Distinct scores
        sc[0] = -16'sd5; sc[1] = 16'sd12; sc[2] = 16'sd300; sc[3] = 16'sd7;
        sc[4] = 16'sh8000; sc[5] = 16'sd299; sc[6] = 16'sd0; sc[7] = 16'sd1;
        sc[8] = 16'sd2; sc[9] = 16'sd3;
        run("distinct", -1, -1, 1'b0);
        check("distinct_const_idx", 32'(bus.class_idx), 2);
        check("distinct_const_val", 32'(bus.class_val), 300);
        check("distinct_const_mg",  32'(bus.margin), 1);

        // Tie between indices 4 and 7, with a start pulse mid-scan
        for (int i = 0; i < int'(NC); i++) sc[i] = 16'sh0100;
        sc[4] = 16'sh0400;
        sc[7] = 16'sh0400;
        run("tie", -1, 4, 1'b0);
        check("tie_const_idx", 32'(bus.class_idx), 4);
        check("tie_const_val", 32'(bus.class_val), 1024);
        check("tie_const_mg",  32'(bus.margin), 0);
        check("tie_no_restart", 32'(bus.busy), 0);

        // Extremes
        for (int i = 0; i < int'(NC); i++) sc[i] = 16'sh8000;
        sc[9] = 16'sh7fff;
        run("ext_max", -1, -1, 1'b0);
        check("ext_max_const_idx", 32'(bus.class_idx), 9);
        check("ext_max_const_mg",  32'(bus.margin), 65535);
        sc[9] = 16'sh8000;
        run("ext_min", -1, -1, 1'b0);
        check("ext_min_const_idx", 32'(bus.class_idx), 0);
        check("ext_min_const_mg",  32'(bus.margin), 0);

        // Start without dnn_done is ignored
        bus.start    = 1'b1;
        bus.dnn_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gate_busy",    32'(bus.busy), 0);
            check("gate_valid",   32'(bus.valid), 0);
            check("gate_out_idx", 32'(bus.out_idx), 0);
        end
        bus.start = 1'b0;

        // Abort at scan cycle 3 keeps the previous results
        for (int i = 0; i < int'(NC); i++) sc[i] = rnd(0);
        run("abort", 3, -1, 1'b0);

        // Reset during scan cycle 5
        for (int i = 0; i < int'(NC); i++) sc[i] = 16'(16'sd100 + 16'(i));
        run("pre_rst", -1, -1, 1'b0);
        bus.start    = 1'b1;
        bus.dnn_done = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_out_idx", 32'(bus.out_idx), 5);
        #2;
        rst_n = 1'b0;
        #1;
        exp_idx    = '0;
        exp_val    = '0;
        exp_margin = '0;
        check("midrst_busy",    32'(bus.busy), 0);
        check("midrst_valid",   32'(bus.valid), 0);
        check("midrst_out_idx", 32'(bus.out_idx), 0);
        check_results("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_idle_busy", 32'(bus.busy), 0);
        run("after_rst", -1, -1, 1'b0);

        // Randomized single runs
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < int'(NC); i++) sc[i] = rnd(r % 3);
            run("rand", -1, -1, 1'b0);
        end

        // Back-to-back with start held high
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < int'(NC); i++) sc[i] = rnd(r % 2);
            run("b2b", -1, -1, 1'b1);
        end
        bus.start = 1'b0;
        tick();
        check("b2b_end_busy", 32'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
